// File: rtl/mb32_acc_stage.sv
// Dot-product accumulator behind the 32b Booth multiplier: aligns operand tags
// with product1, sums signed products with saturation, and queues results in a 2-entry FIFO.
module mb32_acc_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ACC_W   = 72,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               tag_valid,
  input  logic               tag_first,
  input  logic               tag_last,
  input  logic [2*WIDTH-1:0] product1,
  output logic [ACC_W-1:0]   res_data,
  output logic [15:0]        res_terms,
  output logic               res_ovf,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic               err_drop
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned EXT_W = ACC_W - PW;
  localparam int unsigned TW    = 16;
  localparam int unsigned CW    = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  localparam logic [TW-1:0] TERMS_MAX = 16'hFFFF;
  localparam logic [CW-1:0] CNT_ZERO  = 2'd0;
  localparam logic [CW-1:0] CNT_ONE   = 2'd1;
  localparam logic [CW-1:0] CNT_FULL  = 2'd2;

  // ---------------------------------------------------------------------------
  // Tag delay line: bit MUL_LAT-1 lines up with product1
  // ---------------------------------------------------------------------------
  logic [MUL_LAT-1:0] v_sr, f_sr, l_sr;
  logic [MUL_LAT-1:0] v_sr_nx, f_sr_nx, l_sr_nx;
  logic [MUL_LAT:0]   v_ext, f_ext, l_ext;
  logic               d_valid, d_first, d_last;

  always_comb begin
    v_ext   = {v_sr, tag_valid};
    f_ext   = {f_sr, tag_valid & tag_first};
    l_ext   = {l_sr, tag_valid & tag_last};
    v_sr_nx = v_ext[MUL_LAT-1:0];
    f_sr_nx = f_ext[MUL_LAT-1:0];
    l_sr_nx = l_ext[MUL_LAT-1:0];
  end

  assign d_valid = v_sr[MUL_LAT-1];
  assign d_first = f_sr[MUL_LAT-1];
  assign d_last  = l_sr[MUL_LAT-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      v_sr <= '0;
      f_sr <= '0;
      l_sr <= '0;
    end else begin
      v_sr <= v_sr_nx;
      f_sr <= f_sr_nx;
      l_sr <= l_sr_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating accumulate datapath
  // ---------------------------------------------------------------------------
  logic [0:0]       state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [TW-1:0]    terms, terms_nx;
  logic             ovf, ovf_nx;
  logic             emit;

  logic [ACC_W-1:0] p;
  logic [ACC_W:0]   sum;
  logic             sat_hit;
  logic [ACC_W-1:0] acc_sat;
  logic [TW-1:0]    terms_inc;

  assign p   = {{EXT_W{product1[PW-1]}}, product1};
  // One guard bit: overflow iff the two top bits of the widened sum disagree
  assign sum     = {acc[ACC_W-1], acc} + {p[ACC_W-1], p};
  assign sat_hit = sum[ACC_W] ^ sum[ACC_W-1];
  assign acc_sat = !sat_hit ? sum[ACC_W-1:0]
                 : (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}});
  assign terms_inc = (terms == TERMS_MAX) ? terms : terms + 16'd1;

  // Next-state / emit logic; nothing moves unless an aligned term arrives
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    terms_nx = terms;
    ovf_nx   = ovf;
    emit     = 1'b0;
    if (d_valid) begin
      if (d_first) begin
        // Start (or restart) a dot product; any old partial is discarded
        acc_nx   = p;
        terms_nx = 16'd1;
        ovf_nx   = 1'b0;
        if (d_last) begin
          emit     = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_ACC;
        end
      end else if (state == ST_ACC) begin
        acc_nx   = acc_sat;
        terms_nx = terms_inc;
        ovf_nx   = ovf | sat_hit;
        if (d_last) begin
          emit     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      acc   <= '0;
      terms <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      terms <= terms_nx;
      ovf   <= ovf_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry result FIFO: head lives in the output registers, tail behind it
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    count, count_nx;
  logic [ACC_W-1:0] tl_data, tl_data_nx, hd_data_nx;
  logic [TW-1:0]    tl_terms, tl_terms_nx, hd_terms_nx;
  logic             tl_ovf, tl_ovf_nx, hd_ovf_nx;
  logic             pop, full, accept, drop;

  assign pop    = res_valid & res_ready;
  assign full   = (count == CNT_FULL);
  assign accept = emit & (~full | pop);
  assign drop   = emit & full & ~pop;

  always_comb begin
    count_nx    = count;
    hd_data_nx  = res_data;
    hd_terms_nx = res_terms;
    hd_ovf_nx   = res_ovf;
    tl_data_nx  = tl_data;
    tl_terms_nx = tl_terms;
    tl_ovf_nx   = tl_ovf;
    if (pop) begin
      if (count == CNT_FULL) begin
        hd_data_nx  = tl_data;
        hd_terms_nx = tl_terms;
        hd_ovf_nx   = tl_ovf;
        if (accept) begin
          tl_data_nx  = acc_nx;
          tl_terms_nx = terms_nx;
          tl_ovf_nx   = ovf_nx;
        end else begin
          count_nx = CNT_ONE;
        end
      end else if (accept) begin
        hd_data_nx  = acc_nx;
        hd_terms_nx = terms_nx;
        hd_ovf_nx   = ovf_nx;
      end else begin
        count_nx = CNT_ZERO;
      end
    end else if (accept) begin
      if (count == CNT_ZERO) begin
        hd_data_nx  = acc_nx;
        hd_terms_nx = terms_nx;
        hd_ovf_nx   = ovf_nx;
      end else begin
        tl_data_nx  = acc_nx;
        tl_terms_nx = terms_nx;
        tl_ovf_nx   = ovf_nx;
      end
      count_nx = count + CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count     <= CNT_ZERO;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_terms <= '0;
      res_ovf   <= 1'b0;
      tl_data   <= '0;
      tl_terms  <= '0;
      tl_ovf    <= 1'b0;
      err_drop  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      count     <= count_nx;
      res_valid <= (count_nx != CNT_ZERO);
      res_data  <= hd_data_nx;
      res_terms <= hd_terms_nx;
      res_ovf   <= hd_ovf_nx;
      tl_data   <= tl_data_nx;
      tl_terms  <= tl_terms_nx;
      tl_ovf    <= tl_ovf_nx;
      err_drop  <= err_drop | drop;
      busy      <= (state_nx == ST_ACC) | (|v_sr_nx);
    end
  end

endmodule
